maxpool2d_relu: RTL and testbench

- Downstream neighbour of the conv2d stage. Consumes the signed 8-bit feature map that conv2d presents as a whole-array bus with a valid pulse.
- Applies optional ReLU and non-overlapping POOL_SIZE x POOL_SIZE max pooling, then presents the pooled map as a whole-array bus with its own valid flag.
- Sequential: one window element is examined per clock, with an internal snapshot buffer so upstream may change its bus after handoff.

---
 rtl/maxpool2d_relu_if.sv | 18 +
 rtl/maxpool2d_relu.sv | 116 +++++++++++
 tb/tb_maxpool2d_relu.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool2d_relu_if.sv
// Feature-map handoff bus between an upstream stage (master) and the
// pooling block (slave). Both maps travel as whole-array buses.
interface maxpool2d_relu_if #(
  parameter int IN_SIZE    = 26,
  parameter int POOL_SIZE  = 2,
  parameter int DATA_WIDTH = 8
);
  localparam int OUT_SIZE = IN_SIZE / POOL_SIZE;

  logic                         valid_in;
  logic signed [DATA_WIDTH-1:0] feature [0:IN_SIZE*IN_SIZE-1];
  logic                         busy;
  logic                         valid_out;
  logic signed [DATA_WIDTH-1:0] result  [0:OUT_SIZE*OUT_SIZE-1];

  modport master (output valid_in, feature, input busy, valid_out, result);
  modport slave  (input valid_in, feature, output busy, valid_out, result);
endinterface

// File: rtl/maxpool2d_relu.sv
// Sequential non-overlapping max pooling with optional ReLU.
// The input map is snapshotted on handoff, then one window element is
// examined per clock; each finished window is written in place.
module maxpool2d_relu #(
  parameter int IN_SIZE    = 26,
  parameter int POOL_SIZE  = 2,
  parameter int DATA_WIDTH = 8,
  parameter int APPLY_RELU = 1
) (
  input  logic            clk,
  input  logic            rst,
  maxpool2d_relu_if.slave bus
);
  localparam int OUT_SIZE = IN_SIZE / POOL_SIZE;
  localparam int NIN      = IN_SIZE * IN_SIZE;
  localparam int NOUT     = OUT_SIZE * OUT_SIZE;
  localparam int IW       = (NIN > 1) ? $clog2(NIN) : 1;
  localparam int OW       = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int CW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int PW       = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  // Most negative value: any real element ties or beats it.
  localparam logic signed [DATA_WIDTH-1:0] MAX_INIT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SCAN, STORE, DONE} state_t;

  state_t                       state, state_nxt;
  logic [CW-1:0]                row, col;
  logic [PW-1:0]                pi, pj;
  logic signed [DATA_WIDTH-1:0] run_max;
  logic signed [DATA_WIDTH-1:0] fbuf  [0:NIN-1];
  logic signed [DATA_WIDTH-1:0] res_r [0:NOUT-1];
  logic [IW-1:0]                rd_idx;
  logic [OW-1:0]                wr_idx;
  logic signed [DATA_WIDTH-1:0] sample, pooled;
  logic                         start, win_last, map_last;

  // A new map is only accepted when not busy; no queueing.
  assign start    = bus.valid_in && (state == IDLE || state == DONE);
  assign win_last = (pi == PW'(POOL_SIZE-1)) && (pj == PW'(POOL_SIZE-1));
  assign map_last = (row == CW'(OUT_SIZE-1)) && (col == CW'(OUT_SIZE-1));
  assign rd_idx   = IW'((int'(row)*POOL_SIZE + int'(pi))*IN_SIZE
                        + int'(col)*POOL_SIZE + int'(pj));
  assign wr_idx   = OW'(int'(row)*OUT_SIZE + int'(col));
  assign sample   = fbuf[rd_idx];
  assign pooled   = (APPLY_RELU != 0 && run_max < 0) ? '0 : run_max;

  assign bus.busy      = (state == SCAN) || (state == STORE);
  assign bus.valid_out = (state == DONE);
  assign bus.result    = res_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: scan a window, store it, repeat until the last window.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.valid_in) state_nxt = SCAN;
      SCAN:       if (win_last)     state_nxt = STORE;
      STORE:      state_nxt = map_last ? DONE : SCAN;
      default:    state_nxt = IDLE;
    endcase
  end

  // Snapshot of the input map so upstream may move on after handoff.
  always_ff @(posedge clk) begin
    if (!rst && start) fbuf <= bus.feature;
  end

  // Window walk, running max and in-place result writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      row     <= '0;
      col     <= '0;
      pi      <= '0;
      pj      <= '0;
      run_max <= MAX_INIT;
      for (int k = 0; k < NOUT; k++) res_r[k] <= '0;
    end else if (start) begin
      row     <= '0;
      col     <= '0;
      pi      <= '0;
      pj      <= '0;
      run_max <= MAX_INIT;
    end else begin
      case (state)
        SCAN: begin
          // Strictly greater: ties keep the earlier element.
          if (sample > run_max) run_max <= sample;
          if (pj == PW'(POOL_SIZE-1)) begin
            pj <= '0;
            pi <= win_last ? '0 : pi + 1'b1;
          end else begin
            pj <= pj + 1'b1;
          end
        end
        STORE: begin
          res_r[wr_idx] <= pooled;
          run_max       <= MAX_INIT;
          pi            <= '0;
          pj            <= '0;
          if (col == CW'(OUT_SIZE-1)) begin
            col <= '0;
            row <= map_last ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_maxpool2d_relu.sv
// Bench for maxpool2d_relu: two 4x4 instances (ReLU on/off) driven in
// lockstep plus one 5x5 instance; expected pooled maps are queued at
// handoff and popped when valid_out rises.
module tb_maxpool2d_relu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  maxpool2d_relu_if #(.IN_SIZE(4), .POOL_SIZE(2), .DATA_WIDTH(8)) ia();
  maxpool2d_relu_if #(.IN_SIZE(4), .POOL_SIZE(2), .DATA_WIDTH(8)) ib();
  maxpool2d_relu_if #(.IN_SIZE(5), .POOL_SIZE(2), .DATA_WIDTH(8)) ic();

  maxpool2d_relu #(.IN_SIZE(4), .POOL_SIZE(2), .DATA_WIDTH(8), .APPLY_RELU(1))
    dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  maxpool2d_relu #(.IN_SIZE(4), .POOL_SIZE(2), .DATA_WIDTH(8), .APPLY_RELU(0))
    dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  maxpool2d_relu #(.IN_SIZE(5), .POOL_SIZE(2), .DATA_WIDTH(8), .APPLY_RELU(1))
    dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

  typedef int map_t [25];

  int checks = 0;
  int errors = 0;
  logic [31:0] qa[$], qb[$], qc[$];

  // Reference: 2x2 max pooling of an n x n map, result[k] in byte k.
  function automatic logic [31:0] model(map_t m, int n, bit relu);
    logic [31:0] r = '0;
    int mx, v;
    for (int wr = 0; wr < 2; wr++)
      for (int wc = 0; wc < 2; wc++) begin
        mx = -128;
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++) begin
            v = m[(wr*2+i)*n + wc*2 + j];
            if (v > mx) mx = v;
          end
        if (relu && mx < 0) mx = 0;
        r[8*(wr*2+wc) +: 8] = 8'(mx);
      end
    return r;
  endfunction

  function automatic logic [31:0] res(int sel);
    logic [31:0] r;
    for (int k = 0; k < 4; k++)
      r[8*k +: 8] = (sel == 0) ? ia.result[k] : (sel == 1) ? ib.result[k] : ic.result[k];
    return r;
  endfunction

  function automatic logic vo(int sel);
    return (sel == 2) ? ic.valid_out : ia.valid_out;
  endfunction

  function automatic logic bz(int sel);
    return (sel == 2) ? ic.busy : ia.busy;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(int sel, map_t m);
    if (sel == 2) begin
      for (int k = 0; k < 25; k++) ic.feature[k] = 8'(m[k]);
    end else begin
      for (int k = 0; k < 16; k++) begin
        ia.feature[k] = 8'(m[k]);
        ib.feature[k] = 8'(m[k]);
      end
    end
  endtask

  task automatic set_valid(int sel, logic v);
    if (sel == 2) ic.valid_in = v;
    else begin
      ia.valid_in = v;
      ib.valid_in = v;
    end
  endtask

  // Drive a map with a one-cycle valid_in; returns just after the sampling edge.
  task automatic start(int sel, map_t m, bit push);
    load(sel, m);
    if (push) begin
      if (sel == 2) qc.push_back(model(m, 5, 1'b1));
      else begin
        qa.push_back(model(m, 4, 1'b1));
        qb.push_back(model(m, 4, 1'b0));
      end
    end
    set_valid(sel, 1'b1);
    tick();
    set_valid(sel, 1'b0);
  endtask

  task automatic wait_done(int sel, string name);
    int lat = 0;
    while (!vo(sel) && lat < 60) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 20) begin
      errors++;
      $display("FAIL %s latency got %0d expected 20", name, lat);
    end
  endtask

  task automatic pop_check(int sel, string name);
    logic [31:0] e, a;
    checks++;
    if ((sel == 0 && qa.size() == 0) || (sel == 1 && qb.size() == 0) ||
        (sel == 2 && qc.size() == 0)) begin
      errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      if (sel == 0)      e = qa.pop_front();
      else if (sel == 1) e = qb.pop_front();
      else               e = qc.pop_front();
      a = res(sel);
      if (a !== e) begin
        errors++;
        $display("FAIL %s result got %h expected %h", name, a, e);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int s = 0; s < 3; s += 2) begin
      checks++;
      if (vo(s) !== 1'b0) begin errors++; $display("FAIL reset_valid_out%0d got %b expected 0", s, vo(s)); end
      checks++;
      if (bz(s) !== 1'b0) begin errors++; $display("FAIL reset_busy%0d got %b expected 0", s, bz(s)); end
      checks++;
      if (res(s) !== 32'h0) begin errors++; $display("FAIL reset_result%0d got %h expected 0", s, res(s)); end
    end
  endtask

  task automatic test_basic();
    map_t m;
    for (int k = 0; k < 25; k++) m[k] = k;
    start(0, m, 1'b1);
    checks++;
    if (ia.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b expected 1", ia.busy); end
    wait_done(0, "basic");
    pop_check(0, "basic_relu");
    pop_check(1, "basic_norelu");
    checks++;
    if (ia.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got %b expected 0", ia.busy); end
  endtask

  task automatic test_relu();
    map_t m;
    for (int k = 0; k < 25; k++) m[k] = -3;
    start(0, m, 1'b1);
    wait_done(0, "relu");
    pop_check(0, "relu_clamped");
    pop_check(1, "relu_passthru");
  endtask

  task automatic test_signed();
    map_t m;
    for (int k = 0; k < 25; k++) m[k] = 0;
    m[0] = -128; m[1] = 127; m[4] = -1; m[5] = 1;
    start(0, m, 1'b1);
    wait_done(0, "signed");
    pop_check(0, "signed_relu");
    pop_check(1, "signed_norelu");
  endtask

  task automatic test_handoff();
    map_t m, junk;
    int rises = 0, rise_at = -1;
    logic prev;
    for (int k = 0; k < 25; k++) begin m[k] = k; junk[k] = 8'h55; end
    start(0, m, 1'b1);
    prev = ia.valid_out;
    for (int t = 1; t <= 40; t++) begin
      if (t == 1) load(0, junk);
      if (t == 2) set_valid(0, 1'b1);
      if (t == 4) set_valid(0, 1'b0);
      tick();
      if (ia.valid_out && !prev) begin
        rises++;
        if (rise_at < 0) rise_at = t;
      end
      prev = ia.valid_out;
    end
    checks++;
    if (rises != 1) begin errors++; $display("FAIL handoff_rises got %0d expected 1", rises); end
    checks++;
    if (rise_at != 20) begin errors++; $display("FAIL handoff_latency got %0d expected 20", rise_at); end
    pop_check(0, "handoff_relu");
    pop_check(1, "handoff_norelu");
  endtask

  task automatic test_reset_mid();
    map_t m;
    int spurious = 0;
    for (int k = 0; k < 25; k++) m[k] = k;
    start(0, m, 1'b0);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ia.valid_out !== 1'b0) begin errors++; $display("FAIL midrst_valid_out got %b expected 0", ia.valid_out); end
    checks++;
    if (ia.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b expected 0", ia.busy); end
    checks++;
    if (res(0) !== 32'h0) begin errors++; $display("FAIL midrst_result got %h expected 0", res(0)); end
    repeat (25) begin
      tick();
      if (ia.valid_out) spurious++;
    end
    checks++;
    if (spurious != 0) begin errors++; $display("FAIL midrst_no_valid got %0d cycles expected 0", spurious); end
    start(0, m, 1'b1);
    wait_done(0, "midrst_restart");
    pop_check(0, "midrst_relu");
    pop_check(1, "midrst_norelu");
  endtask

  task automatic test_back_to_back();
    map_t m;
    for (int k = 0; k < 25; k++) m[k] = (k < 16) ? 15 - k : 0;
    start(0, m, 1'b1);
    checks++;
    if (ia.valid_out !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop got %b expected 0", ia.valid_out); end
    checks++;
    if (ia.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b expected 1", ia.busy); end
    wait_done(0, "b2b");
    pop_check(0, "b2b_relu");
    pop_check(1, "b2b_norelu");
  endtask

  task automatic test_odd_size();
    map_t m;
    for (int k = 0; k < 25; k++) m[k] = k;
    // Elements outside every window carry a large value that must never win.
    m[4] = 127; m[9] = 127; m[14] = 127;
    for (int k = 19; k < 25; k++) m[k] = 127;
    start(2, m, 1'b1);
    wait_done(2, "odd");
    pop_check(2, "odd_result");
  endtask

  initial begin
    ia.valid_in = 1'b0; ib.valid_in = 1'b0; ic.valid_in = 1'b0;
    for (int k = 0; k < 16; k++) begin ia.feature[k] = '0; ib.feature[k] = '0; end
    for (int k = 0; k < 25; k++) ic.feature[k] = '0;
    test_reset();
    test_basic();
    test_relu();
    test_signed();
    test_handoff();
    test_reset_mid();
    test_back_to_back();
    test_odd_size();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
